// File: rtl/cbus_rr_arbiter.sv
// N-to-1 CBus arbiter with zero-latency grant, fixed or round-robin policy,
// burst locking to a single owner and a sticky protocol-error flag.
module cbus_rr_arbiter #(
  parameter  int unsigned NUM_INPUTS  = 2,
  parameter  int unsigned ROUND_ROBIN = 1,
  parameter  int unsigned DATA_W      = 32,
  parameter  int unsigned REQ_W       = 72,
  localparam int unsigned IDX_W       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int unsigned RESP_W      = DATA_W + 2
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [NUM_INPUTS-1:0][REQ_W-1:0]    ireqs,
  output logic [NUM_INPUTS-1:0][RESP_W-1:0]   iresps,
  output logic [REQ_W-1:0]                    oreq,
  input  logic [RESP_W-1:0]                   oresp,
  output logic                                grant_valid,
  output logic [IDX_W-1:0]                    grant_index,
  output logic                                protocol_err
);

  // Request word: valid in the MSB. Response word: {ready, last, data}.
  localparam int unsigned REQ_VALID_BIT  = REQ_W - 1;
  localparam int unsigned RESP_READY_BIT = RESP_W - 1;
  localparam int unsigned RESP_LAST_BIT  = RESP_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_lock_idx;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic                    r_protocol_err;

  logic [NUM_INPUTS-1:0]   w_valid;
  logic                    w_sel_valid;
  logic [IDX_W-1:0]        w_sel_idx;
  logic                    w_own_valid;
  logic [IDX_W-1:0]        w_own_idx;
  logic                    w_lock_valid;
  logic                    w_abort;
  logic                    w_resp_done;
  logic                    w_complete;
  logic [REQ_W-1:0]        w_own_req;

  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      w_valid[i] = ireqs[i][REQ_VALID_BIT];
    end
  end

  assign w_resp_done = oresp[RESP_READY_BIT] & oresp[RESP_LAST_BIT];

  // Scan starts at rr_ptr in round-robin mode and at 0 in fixed mode; the
  // first valid requester found wins.
  always_comb begin
    int unsigned j;
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    j           = 0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (ROUND_ROBIN != 0) begin
        j = 32'(r_rr_ptr) + k;
        if (j >= NUM_INPUTS) begin
          j = j - NUM_INPUTS;
        end
      end else begin
        j = k;
      end
      if (!w_sel_valid && w_valid[j]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    w_lock_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (IDX_W'(i) == r_lock_idx) begin
        w_lock_valid = w_valid[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_own_valid = 1'b0;
    w_own_idx   = '0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_valid) begin
          w_own_valid = 1'b1;
          w_own_idx   = w_sel_idx;
          if (!w_resp_done) begin
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // The owner keeps its response path during an abort; only the
        // downstream request is withdrawn.
        w_own_valid = 1'b1;
        w_own_idx   = r_lock_idx;
        if (!w_lock_valid) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_resp_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign w_complete = w_own_valid & ~w_abort & w_resp_done;

  always_comb begin
    w_own_req = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (IDX_W'(i) == w_own_idx) begin
        w_own_req = ireqs[i];
      end
    end
  end

  always_comb begin
    oreq = (w_own_valid && !w_abort) ? w_own_req : '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = (w_own_valid && (IDX_W'(i) == w_own_idx)) ? oresp : '0;
    end
  end

  assign grant_valid  = w_own_valid;
  assign grant_index  = w_own_valid ? w_own_idx : '0;
  assign protocol_err = r_protocol_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_lock_idx     <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_sel_valid && !w_resp_done) begin
        r_lock_idx <= w_sel_idx;
      end
      if (w_abort) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  // Pointer advances past the owner only on a real completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= '0;
    end else if ((ROUND_ROBIN != 0) && w_complete) begin
      if (w_own_idx == LAST_IDX) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_own_idx + IDX_W'(1);
      end
    end
  end

endmodule
